// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//   Iterative multiplier / divider that feeds the HI/LO registers of a
//   multicycle MIPS datapath. One operation at a time: the control FSM pulses
//   start_mult or start_div for one cycle, waits for done, then copies hi/lo.
//
//   Multiply : shift-add on operand magnitudes, one multiplier bit per cycle.
//   Divide   : restoring division on magnitudes, one quotient bit per cycle.
//   Signs are applied once, in the FIN cycle, so the iteration is unsigned.
//
// Parameters
//   WIDTH   operand width (4..64); hi and lo are WIDTH bits each
//   SIGNED  1 = two's-complement MULT/DIV, 0 = unsigned MULTU/DIVU
//
// Ports
//   clock       rising-edge clock
//   reset       asynchronous, active-high; returns every register to 0
//   start_mult  one-cycle multiply request (wins if start_div is also high)
//   start_div   one-cycle divide request
//   a, b        operands, sampled only when a start is accepted in IDLE
//   hi, lo      mult: {hi,lo} = product; div: hi = remainder, lo = quotient
//   busy        high while the iteration (MULT or DIV) is running
//   done        one-cycle pulse once hi/lo hold the final result
//   div_zero    raised with done for a zero divisor; cleared by the next start
// -----------------------------------------------------------------------------
module mult_div_unit #(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_DIV  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  // Which result the FIN cycle has to publish.
  typedef enum logic [1:0] {
    OP_MULT = 2'd0,
    OP_DIV  = 2'd1,
    OP_DZ   = 2'd2
  } op_t;

  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;      // |multiplicand| or |divisor|
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;  // running upper product half / remainder
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;  // multiplier bits / dividend-then-quotient
  logic             neg_lo_q, neg_lo_d;  // product or quotient must be negated
  logic             neg_hi_q, neg_hi_d;  // remainder must be negated
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  // Magnitude of an operand. The most negative value maps onto itself, which
  // read as unsigned is exactly its magnitude, so MIN needs no special case.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return (SIGNED && x[WIDTH-1]) ? -x : x;
  endfunction

  // One shift-add step: add the multiplicand when the current multiplier bit
  // is set, then shift the {acc_hi, acc_lo} pair right by one. The carry of
  // the add becomes the new top bit of acc_hi.
  logic [WIDTH-1:0] mul_addend;
  logic [WIDTH:0]   mul_sum;
  assign mul_addend = acc_lo_q[0] ? opnd_q : '0;
  assign mul_sum    = {1'b0, acc_hi_q} + {1'b0, mul_addend};

  // One restoring-division step: bring the next dividend bit into the partial
  // remainder and try to subtract the divisor. A set top bit of the trial
  // difference means it went negative, so the old shifted remainder is kept.
  logic [WIDTH:0] div_shift;
  logic [WIDTH:0] div_trial;
  assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, opnd_q};

  // Full-width product with the sign applied as one 2*WIDTH-bit negation.
  logic [2*WIDTH-1:0] prod_mag;
  logic [2*WIDTH-1:0] prod_fix;
  assign prod_mag = {acc_hi_q, acc_lo_q};
  assign prod_fix = neg_lo_q ? -prod_mag : prod_mag;

  // NOTE: every variable written in this block is assigned a default first, so
  // no path through the case statements can leave one unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    opnd_d   = opnd_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dz_d     = dz_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_mult || start_div) begin
          // Common latching for every accepted request; the zero-divisor path
          // loads these too but never publishes them.
          dz_d     = 1'b0;
          cnt_d    = '0;
          acc_hi_d = '0;
          acc_lo_d = mag(a);
          opnd_d   = mag(b);
          neg_lo_d = SIGNED && (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_hi_d = SIGNED && a[WIDTH-1];
          if (start_mult) begin
            op_d    = OP_MULT;
            state_d = S_MULT;
            busy_d  = 1'b1;
          end else if (b == '0) begin
            op_d    = OP_DZ;
            state_d = S_FIN;
          end else begin
            op_d    = OP_DIV;
            state_d = S_DIV;
            busy_d  = 1'b1;
          end
        end
      end

      S_MULT: begin
        acc_hi_d = mul_sum[WIDTH:1];
        acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = S_FIN;
      end

      S_DIV: begin
        if (!div_trial[WIDTH]) begin
          acc_hi_d = div_trial[WIDTH-1:0];
          acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_hi_d = div_shift[WIDTH-1:0];
          acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = S_FIN;
      end

      S_FIN: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        unique case (op_q)
          OP_MULT: {hi_d, lo_d} = prod_fix;
          OP_DIV: begin
            // Quotient truncates toward zero; remainder follows the dividend.
            lo_d = neg_lo_q ? -acc_lo_q : acc_lo_q;
            hi_d = neg_hi_q ? -acc_hi_q : acc_hi_q;
          end
          default: dz_d = 1'b1;  // zero divisor: hi/lo keep their old values
        endcase
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= OP_MULT;
      cnt_q    <= '0;
      opnd_q   <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      opnd_q   <= opnd_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mult_div_unit
//   Two instances share all stimulus: u_dut_s (SIGNED=1) and u_dut_u
//   (SIGNED=0). A behavioural model computes results with plain 64-bit
//   arithmetic and tracks when they must appear; a compare process checks both
//   instances against it every cycle. Directed tests add literal expectations.
// -----------------------------------------------------------------------------
module tb_mult_div_unit;

  localparam int WIDTH = 32;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             start_mult = 1'b0;
  logic             start_div = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;

  logic [WIDTH-1:0] hi_s, lo_s, hi_u, lo_u;
  logic             busy_s, done_s, dz_s;
  logic             busy_u, done_u, dz_u;

  int total = 0;
  int bad   = 0;
  logic cmp_en = 1'b0;

  always #5 clock = ~clock;

  mult_div_unit #(.WIDTH(WIDTH), .SIGNED(1'b1)) u_dut_s (
    .clock(clock), .reset(reset), .start_mult(start_mult), .start_div(start_div),
    .a(a), .b(b), .hi(hi_s), .lo(lo_s), .busy(busy_s), .done(done_s), .div_zero(dz_s)
  );

  mult_div_unit #(.WIDTH(WIDTH), .SIGNED(1'b0)) u_dut_u (
    .clock(clock), .reset(reset), .start_mult(start_mult), .start_div(start_div),
    .a(a), .b(b), .hi(hi_u), .lo(lo_u), .busy(busy_u), .done(done_u), .div_zero(dz_u)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  // Result as {hi, lo} straight from integer arithmetic.
  function automatic logic [63:0] model_result(input bit sgn, input bit is_mult,
                                               input logic [31:0] x, input logic [31:0] y);
    longint          sx, sy, q, rm;
    longint unsigned ux, uy;
    logic [63:0]     r;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'd0, x};
    uy = {32'd0, y};
    if (is_mult) begin
      if (sgn) r = sx * sy;
      else     r = ux * uy;
    end else if (sgn) begin
      q  = sx / sy;
      rm = sx % sy;
      r  = {rm[31:0], q[31:0]};
    end else begin
      q  = longint'(ux / uy);
      rm = longint'(ux % uy);
      r  = {rm[31:0], q[31:0]};
    end
    return r;
  endfunction

  // Index 0 models the signed instance, index 1 the unsigned one. Timing is
  // identical for both: the result appears WIDTH+1 edges after acceptance
  // (1 edge for a zero divisor); busy covers the iteration only.
  logic        running;
  int          remain;
  logic        pend_dz;
  logic        m_busy, m_done, m_dz;
  logic [63:0] r_full [2];
  logic [31:0] m_hi [2];
  logic [31:0] m_lo [2];

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      running <= 1'b0;
      remain  <= 0;
      pend_dz <= 1'b0;
      m_busy  <= 1'b0;
      m_done  <= 1'b0;
      m_dz    <= 1'b0;
      for (int k = 0; k < 2; k++) begin
        r_full[k] <= '0;
        m_hi[k]   <= '0;
        m_lo[k]   <= '0;
      end
    end else begin
      m_done <= 1'b0;
      if (!running) begin
        if (start_mult || start_div) begin
          running <= 1'b1;
          m_dz    <= 1'b0;
          if (!start_mult && b == '0) begin
            remain  <= 1;
            pend_dz <= 1'b1;
          end else begin
            remain  <= WIDTH + 1;
            pend_dz <= 1'b0;
            m_busy  <= 1'b1;
            for (int k = 0; k < 2; k++)
              r_full[k] <= model_result(k == 0, start_mult, a, b);
          end
        end
      end else if (remain == 1) begin
        running <= 1'b0;
        remain  <= 0;
        m_done  <= 1'b1;
        m_busy  <= 1'b0;
        if (pend_dz) m_dz <= 1'b1;
        else begin
          for (int k = 0; k < 2; k++) begin
            m_hi[k] <= r_full[k][63:32];
            m_lo[k] <= r_full[k][31:0];
          end
        end
      end else begin
        remain <= remain - 1;
      end
    end
  end

  // Compare process: both instances against the model on every falling edge.
  always @(negedge clock) begin
    if (cmp_en) begin
      check("cyc_busy_s", busy_s, m_busy);
      check("cyc_done_s", done_s, m_done);
      check("cyc_dz_s",   dz_s,   m_dz);
      check("cyc_hi_s",   hi_s,   m_hi[0]);
      check("cyc_lo_s",   lo_s,   m_lo[0]);
      check("cyc_busy_u", busy_u, m_busy);
      check("cyc_done_u", done_u, m_done);
      check("cyc_dz_u",   dz_u,   m_dz);
      check("cyc_hi_u",   hi_u,   m_hi[1]);
      check("cyc_lo_u",   lo_u,   m_lo[1]);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  // Issues one request and waits (bounded) for done. lat counts falling edges
  // after the accepting rising edge; the loop exits on the edge where done=1.
  // inject_at pulses start_div at that count; abort_at asserts reset mid-cycle.
  task automatic do_op(input logic m, input logic d, input logic [31:0] av,
                       input logic [31:0] bv, input int inject_at, input int abort_at,
                       output int lat, output int busy_cnt, output logic dz_first);
    bit finished;
    lat      = 0;
    busy_cnt = 0;
    dz_first = 1'b0;
    finished = 1'b0;
    @(negedge clock);
    start_mult = m;
    start_div  = d;
    a = av;
    b = bv;
    while (!finished && lat < 100) begin
      @(negedge clock);
      lat++;
      start_mult = 1'b0;
      start_div  = (lat == inject_at);
      if (lat == 1) dz_first = dz_s;
      if (busy_s) busy_cnt++;
      if (lat == abort_at) begin
        #2 reset = 1'b1;
        #1;
        check("rst_busy_s", busy_s, 1'b0);
        check("rst_done_s", done_s, 1'b0);
        check("rst_hi_u",   hi_u,   32'h0);
        check("rst_lo_s",   lo_s,   32'h0);
        check("rst_hi_s",   hi_s,   32'h0);
        finished = 1'b1;
      end else if (done_s) begin
        finished = 1'b1;
      end
    end
    start_div = 1'b0;
    check("op_finished", finished, 1'b1);
  endtask

  int   lat, bcnt, extra;
  logic dz1;

  initial begin
    #1 reset = 1'b1;
    #1 cmp_en = 1'b1;
    check("reset_hi",   hi_s,   32'h0);
    check("reset_lo",   lo_s,   32'h0);
    check("reset_busy", busy_s, 1'b0);
    check("reset_done", done_s, 1'b0);
    check("reset_dz",   dz_s,   1'b0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // 1: signed -3 * 7
    do_op(1'b1, 1'b0, 32'hFFFF_FFFD, 32'd7, 0, 0, lat, bcnt, dz1);
    check("t1_latency", lat, 34);
    check("t1_busy_cycles", bcnt, 33);
    check("t1_hi", hi_s, 32'hFFFF_FFFF);
    check("t1_lo", lo_s, 32'hFFFF_FFEB);

    // 2: signed -7 / 2
    do_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 0, 0, lat, bcnt, dz1);
    check("t2_latency", lat, 34);
    check("t2_lo", lo_s, 32'hFFFF_FFFD);
    check("t2_hi", hi_s, 32'hFFFF_FFFF);
    check("t2_dz", dz_s, 1'b0);

    // 3: divide by zero, then a multiply clears the flag on accept
    do_op(1'b0, 1'b1, 32'd5, 32'd0, 0, 0, lat, bcnt, dz1);
    check("t3_latency", lat, 2);
    check("t3_busy_cycles", bcnt, 0);
    check("t3_dz", dz_s, 1'b1);
    check("t3_hi_kept", hi_s, 32'hFFFF_FFFF);
    check("t3_lo_kept", lo_s, 32'hFFFF_FFFD);
    do_op(1'b1, 1'b0, 32'd2, 32'd3, 0, 0, lat, bcnt, dz1);
    check("t3b_dz_cleared", dz1, 1'b0);
    check("t3b_hi", hi_s, 32'h0);
    check("t3b_lo", lo_s, 32'd6);

    // 4: simultaneous starts -> multiply; start_div mid-MULT is ignored
    do_op(1'b1, 1'b1, 32'd4, 32'd2, 0, 0, lat, bcnt, dz1);
    check("t4_latency", lat, 34);
    check("t4_hi", hi_s, 32'h0);
    check("t4_lo", lo_s, 32'd8);
    do_op(1'b1, 1'b0, 32'd9, 32'd9, 5, 0, lat, bcnt, dz1);
    check("t4b_lo", lo_s, 32'd81);
    extra = 0;
    repeat (40) begin
      @(negedge clock);
      if (done_s) extra++;
    end
    check("t4b_single_done", extra, 0);

    // 5: MIN / -1, signed and unsigned interpretations
    do_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, lat, bcnt, dz1);
    check("t5_lo_s", lo_s, 32'h8000_0000);
    check("t5_hi_s", hi_s, 32'h0);
    check("t5_dz_s", dz_s, 1'b0);
    check("t5_lo_u", lo_u, 32'h0);
    check("t5_hi_u", hi_u, 32'h8000_0000);

    // 6: reset during a multiply, then an unsigned max*max
    do_op(1'b1, 1'b0, 32'd1234, 32'd5678, 0, 10, lat, bcnt, dz1);
    @(negedge clock);
    reset = 1'b0;
    do_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, lat, bcnt, dz1);
    check("t6_hi_u", hi_u, 32'hFFFF_FFFE);
    check("t6_lo_u", lo_u, 32'h0000_0001);
    check("t6_hi_s", hi_s, 32'h0);
    check("t6_lo_s", lo_s, 32'h0000_0001);

    repeat (3) @(negedge clock);
    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

endmodule
